// File: rtl/pcs25g_errinj_pkg.sv
// ---------------------------------------------------------------------------
// pcs25g_errinj_pkg
// Shared definitions for the pcs25g testbench error-injector scheduler:
// injector mode codes and the campaign sequencing state enum.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pcs25g_errinj_pkg;

  // Injector 2-bit mode encoding (bit-error ratio selected by the injector).
  localparam logic [1:0] ERRINJ_NONE = 2'b00;
  localparam logic [1:0] ERRINJ_E3   = 2'b01;
  localparam logic [1:0] ERRINJ_E5   = 2'b10;
  localparam logic [1:0] ERRINJ_E7   = 2'b11;

  // Campaign sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  // Mode code that produces errors (anything other than NONE).
  function automatic logic mode_injects(input logic [1:0] mode);
    return mode != ERRINJ_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a set request
// starts at index ptr and wraps; the first set bit found wins.
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  PTR_W  index with highest priority this round
//   winner_c  out N_REQ  one-hot winner (all zero when req is zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner_c
);

  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] dbl_win;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_win;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_req  = {req, req} >> ptr;
    rot_req  = dbl_req[N_REQ-1:0];
    rot_win  = rot_req & (~rot_req + N_REQ'(1));
    dbl_win  = {rot_win, rot_win} << ptr;
    winner_c = dbl_win[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/err_inject_sched.sv
// ---------------------------------------------------------------------------
// err_inject_sched
// Scheduler in front of the pcs25g testbench error injector. Arbitrates
// round-robin between N_REQ campaign requesters and sequences the injector
// mode: apply mode, wait SETTLE_CYC, hold for len words, return to NONE,
// wait SETTLE_CYC, then pulse done to the owner. One campaign at a time.
//
// Optional statistics counters are enabled by defining ERRINJ_SCHED_STATS_EN.
//
// Ports:
//   clk                in   clock shared with the injector
//   reset              in   synchronous active-high reset
//   req                in   per-requester request level
//   req_mode           in   per-requester mode, slice i = [2i+1:2i]
//   req_len            in   per-requester campaign length in words
//   abort              in   pulse terminating the active campaign
//   grant              out  one-hot injector owner, held for the campaign
//   done               out  one-cycle pulse to the owner at campaign end
//   aborted            out  with done: campaign ended by abort
//   inj_mode           out  injector mode input
//   inj_active         out  high while the campaign mode is on the injector output
//   busy               out  high in every state except IDLE
//   words_left         out  remaining RUN words, 0 outside RUN
//   campaigns_done     out  (stats build) saturating count of completed campaigns
//   campaigns_aborted  out  (stats build) saturating count of aborted campaigns
// ---------------------------------------------------------------------------
module err_inject_sched
  import pcs25g_errinj_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_mode,
  input  logic [LEN_W*N_REQ-1:0] req_len,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   aborted,
  output logic [1:0]             inj_mode,
  output logic                   inj_active,
  output logic                   busy,
  output logic [LEN_W-1:0]       words_left
`ifdef ERRINJ_SCHED_STATS_EN
  ,
  output logic [15:0]            campaigns_done,
  output logic [15:0]            campaigns_aborted
`endif
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);

  sched_state_e      state;
  logic [PTR_W-1:0]  ptr;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt;
  logic              abort_q;

  logic [N_REQ-1:0]  winner_c;
  logic [1:0]        win_mode_c;
  logic [LEN_W-1:0]  win_len_c;
  logic [PTR_W-1:0]  owner_idx_c;
  logic [PTR_W-1:0]  ptr_next_c;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req      (req),
    .ptr      (ptr),
    .winner_c (winner_c)
  );

  // Select the winner's mode and length slices.
  always_comb begin
    win_mode_c = '0;
    win_len_c  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_mode_c = win_mode_c | (req_mode[2*i +: 2] & {2{winner_c[i]}});
      win_len_c  = win_len_c  | (req_len[LEN_W*i +: LEN_W] & {LEN_W{winner_c[i]}});
    end
  end

  // Owner index from the one-hot grant; the next round starts just after it.
  always_comb begin
    owner_idx_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner_idx_c = PTR_W'(i);
      end
    end
    ptr_next_c = (owner_idx_c == PTR_MAX) ? '0 : owner_idx_c + PTR_W'(1);
  end

  // Campaign sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      len_q      <= '0;
      cnt        <= '0;
      abort_q    <= 1'b0;
      grant      <= '0;
      done       <= '0;
      aborted    <= 1'b0;
      inj_mode   <= ERRINJ_NONE;
      inj_active <= 1'b0;
      busy       <= 1'b0;
      words_left <= '0;
`ifdef ERRINJ_SCHED_STATS_EN
      campaigns_done    <= '0;
      campaigns_aborted <= '0;
`endif
    end else begin
      done    <= '0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= winner_c;
            inj_mode <= win_mode_c;
            len_q    <= win_len_c;
            cnt      <= CNT_LAST;
            abort_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            abort_q  <= 1'b1;
            inj_mode <= ERRINJ_NONE;
            cnt      <= CNT_LAST;
            state    <= DRAIN;
          end else if (cnt == '0) begin
            if (len_q == '0) begin
              // Zero-length campaign skips RUN entirely.
              inj_mode <= ERRINJ_NONE;
              cnt      <= CNT_LAST;
              state    <= DRAIN;
            end else begin
              words_left <= len_q;
              inj_active <= 1'b1;
              state      <= RUN;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RUN: begin
          // The final word wins over a coincident abort.
          if (words_left == LEN_W'(1) || abort) begin
            abort_q    <= (words_left != LEN_W'(1));
            inj_mode   <= ERRINJ_NONE;
            inj_active <= 1'b0;
            words_left <= '0;
            cnt        <= CNT_LAST;
            state      <= DRAIN;
          end else begin
            words_left <= words_left - LEN_W'(1);
          end
        end

        DRAIN: begin
          if (cnt == '0) begin
            done    <= grant;
            aborted <= abort_q;
            state   <= DONE;
`ifdef ERRINJ_SCHED_STATS_EN
            if (campaigns_done != 16'hFFFF) begin
              campaigns_done <= campaigns_done + 16'd1;
            end
            if (abort_q && campaigns_aborted != 16'hFFFF) begin
              campaigns_aborted <= campaigns_aborted + 16'd1;
            end
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_next_c;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
